ramp_arbiter: RTL and testbench

- Arbitrates the single-lane entry/exit ramp of the parking lot between inbound and outbound vehicles.
- Drives the per-direction traffic lights and the barrier gate.
- Holds each grant until the vehicle-transit FSM reports completion (ingreso/egreso pulse), then enforces an all-red clearance interval.
- Sits between the debounced request loops, the transit FSM and the occupancy counter; refuses entry when the lot is full.

---
 rtl/ramp_pkg.sv | 14 +
 rtl/ramp_timer.sv | 20 ++
 rtl/ramp_arbiter.sv | 116 +++++++++++
 tb/tb_ramp_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// ramp_pkg: shared state encoding, direction constants and lot sizing for the ramp arbiter and vehicle counter
package ramp_pkg;
    localparam int RAMP_CAP   = 7;
    localparam int RAMP_CNT_W = 3;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT_IN  = 2'd1;
    localparam logic [1:0] GRANT_OUT = 2'd2;
    localparam logic [1:0] CLEAR     = 2'd3;
    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/ramp_timer.sv
// ramp_timer: loadable down-counter that holds at zero, shared by clearance and grant timeout
// Ports: clk, rst (async, active-high), load/load_val (load takes priority over counting), zero (count == 0)
module ramp_timer
    import ramp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = (cnt == '0);
endmodule

// File: rtl/ramp_arbiter.sv
// ramp_arbiter: single-lane ramp arbiter driving lights and barrier, round-robin between entry and exit
// Ports: clk, rst (async, active-high); req_in/req_out debounced request levels; count occupancy;
//        ingreso/egreso transit-complete pulses; green_in/green_out/gate_open/busy/full registered outputs;
//        timeout_err sticky force-release flag.
// Build option: RAMP_TIMEOUT_EN enables the grant timeout; without it grants wait for their pulse and
//        timeout_err is constant 0.
module ramp_arbiter
    import ramp_pkg::*;
#(
    parameter int CAP         = RAMP_CAP,
    parameter int CNT_W       = RAMP_CNT_W,
    parameter int CLEAR_CYC   = 1000,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             req_out,
    input  logic [CNT_W-1:0] count,
    input  logic             ingreso,
    input  logic             egreso,
    output logic             green_in,
    output logic             green_out,
    output logic             gate_open,
    output logic             busy,
    output logic             full,
    output logic             timeout_err
);
    localparam int TW_RAW = $clog2(max_int(CLEAR_CYC, TIMEOUT_CYC));
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] C_LOAD = TW'(CLEAR_CYC - 1);
`ifdef RAMP_TIMEOUT_EN
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC - 1);
    logic to_err;
`endif
    logic [1:0]    st, nxt;
    logic          last_dir, dir_n, load, t_zero, el_in, el_out, done;
    logic [TW-1:0] lval;
    assign el_in  = req_in && !(int'(count) >= CAP);
    assign el_out = req_out;
    // only the pulse matching the granted direction completes it
    assign done   = (st == GRANT_IN) ? ingreso : egreso;
    ramp_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(lval),
        .zero    (t_zero)
    );
    always_comb begin
        nxt   = st;
        dir_n = last_dir;
        load  = 1'b0;
        lval  = C_LOAD;
`ifdef RAMP_TIMEOUT_EN
        to_err = 1'b0;
`endif
        case (st)
            IDLE: begin
                if (el_in && (!el_out || last_dir == DIR_OUT)) begin
                    nxt   = GRANT_IN;
                    dir_n = DIR_IN;
                end else if (el_out) begin
                    nxt   = GRANT_OUT;
                    dir_n = DIR_OUT;
                end
            end
            GRANT_IN, GRANT_OUT: begin
                // a completion pulse wins over a simultaneous expiry
                if (done) begin
                    nxt  = CLEAR;
                    load = 1'b1;
                end
`ifdef RAMP_TIMEOUT_EN
                else if (t_zero) begin
                    nxt    = CLEAR;
                    load   = 1'b1;
                    to_err = 1'b1;
                end
`endif
            end
            default: if (t_zero) nxt = IDLE;
        endcase
`ifdef RAMP_TIMEOUT_EN
        if (st == IDLE && nxt != IDLE) begin
            load = 1'b1;
            lval = T_LOAD;
        end
`endif
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st        <= IDLE;
            last_dir  <= DIR_OUT;
            green_in  <= 1'b0;
            green_out <= 1'b0;
            gate_open <= 1'b0;
            busy      <= 1'b0;
            full      <= 1'b0;
        end else begin
            st        <= nxt;
            last_dir  <= dir_n;
            green_in  <= (nxt == GRANT_IN);
            green_out <= (nxt == GRANT_OUT);
            gate_open <= (nxt == GRANT_IN) || (nxt == GRANT_OUT);
            busy      <= (nxt != IDLE);
            full      <= (int'(count) >= CAP);
        end
`ifdef RAMP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) timeout_err <= 1'b0;
        else timeout_err <= timeout_err | to_err;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_ramp_arbiter.sv
// tb_ramp_arbiter: directed vector bench for ramp_arbiter with CLEAR_CYC=4, TIMEOUT_CYC=20
module tb_ramp_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_in = 1'b0, req_out = 1'b0, ingreso = 1'b0, egreso = 1'b0;
    logic [2:0] count = 3'd0;
    logic       green_in, green_out, gate_open, busy, full, timeout_err;
    logic [5:0] o;
    int         n_vec = 0;
    int         n_err = 0;

    // {green_in, green_out, gate_open, busy, full, timeout_err}
    localparam logic [5:0] E_ID = 6'b000000;
    localparam logic [5:0] E_GI = 6'b101100;
    localparam logic [5:0] E_GO = 6'b011100;
    localparam logic [5:0] E_CL = 6'b000100;
    localparam logic [5:0] F    = 6'b000010;
    localparam logic [5:0] ER   = 6'b000001;

    typedef struct {
        logic       ri;
        logic       ro;
        logic [2:0] cnt;
        logic       ig;
        logic       eg;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    ramp_arbiter #(.CAP(7), .CNT_W(3), .CLEAR_CYC(4), .TIMEOUT_CYC(20)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out), .count(count),
        .ingreso(ingreso), .egreso(egreso), .green_in(green_in), .green_out(green_out),
        .gate_open(gate_open), .busy(busy), .full(full), .timeout_err(timeout_err)
    );

    assign o = {green_in, green_out, gate_open, busy, full, timeout_err};
    always #5 clk = ~clk;

    function automatic void add(input logic ri, input logic ro, input logic [2:0] c,
                                input logic ig, input logic eg, input logic [5:0] e);
        vec_t v;
        v.ri = ri; v.ro = ro; v.cnt = c; v.ig = ig; v.eg = eg; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] exp);
        n_vec++;
        if (o !== exp) begin
            n_err++;
            $display("FAIL %s: outputs %b, expected %b", nm, o, exp);
        end
    endtask

    task automatic set(input logic ri, input logic ro, input logic ig, input logic eg);
        req_in = ri; req_out = ro; ingreso = ig; egreso = eg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // contention from reset: IN, OUT, IN; wrong-direction pulses ignored
        add(1, 1, 2, 0, 0, E_GI);
        add(1, 1, 2, 0, 1, E_GI);
        add(1, 1, 2, 1, 0, E_CL);
        for (int i = 0; i < 3; i++) add(1, 1, 2, 0, 0, E_CL);
        add(1, 1, 2, 0, 0, E_ID);
        add(1, 1, 2, 0, 0, E_GO);
        add(1, 1, 2, 1, 0, E_GO);
        add(1, 1, 2, 0, 1, E_CL);
        for (int i = 0; i < 3; i++) add(1, 1, 2, 0, 0, E_CL);
        add(1, 1, 2, 0, 0, E_ID);
        add(1, 1, 2, 0, 0, E_GI);
        add(0, 0, 2, 1, 0, E_CL);
        for (int i = 0; i < 3; i++) add(0, 0, 2, 0, 0, E_CL);
        add(0, 0, 2, 0, 0, E_ID);
        // single entry; dropped request keeps the grant
        add(1, 0, 2, 0, 0, E_GI);
        add(0, 0, 2, 0, 0, E_GI);
        add(0, 0, 2, 1, 0, E_CL);
        for (int i = 0; i < 3; i++) add(0, 0, 2, 0, 0, E_CL);
        add(0, 0, 2, 0, 0, E_ID);
        add(0, 0, 2, 0, 0, E_ID);
        // full lot refuses entry, exit still granted
        add(1, 0, 7, 0, 0, E_ID | F);
        add(1, 0, 7, 0, 0, E_ID | F);
        add(1, 1, 7, 0, 0, E_GO | F);
        add(0, 0, 7, 0, 1, E_CL | F);
        for (int i = 0; i < 3; i++) add(0, 0, 7, 0, 0, E_CL | F);
        add(0, 0, 7, 0, 0, E_ID | F);
        // lot fills during an inbound grant: grant kept
        add(1, 0, 6, 0, 0, E_GI);
        add(0, 0, 7, 0, 0, E_GI | F);
        add(0, 0, 7, 1, 0, E_CL | F);
        for (int i = 0; i < 3; i++) add(0, 0, 7, 0, 0, E_CL | F);
        add(0, 0, 7, 0, 0, E_ID | F);
        // exit granted at count 0
        add(0, 1, 0, 0, 0, E_GO);
        add(0, 0, 0, 0, 1, E_CL);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, E_CL);
        add(0, 0, 0, 0, 0, E_ID);

        cyc();
        chk("reset", E_ID);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            set(tbl[i].ri, tbl[i].ro, tbl[i].ig, tbl[i].eg);
            count = tbl[i].cnt;
            cyc();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end
        set(0, 0, 0, 0);
        count = 3'd0;

        // withheld ingreso
        set(1, 0, 0, 0);
        cyc();
        chk("to_grant", E_GI);
        set(0, 0, 0, 0);
        for (int k = 1; k < 20; k++) begin
            cyc();
            chk($sformatf("to_hold%0d", k), E_GI);
        end
        cyc();
`ifdef RAMP_TIMEOUT_EN
        chk("to_expire", E_CL | ER);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("to_clear", E_CL | ER);
        end
        cyc();
        chk("to_sticky", E_ID | ER);
`else
        chk("no_timeout_hold", E_GI);
        set(1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("no_timeout_done", E_CL);
        set(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("no_timeout_clear", E_CL);
        end
        cyc();
        chk("no_timeout_idle", E_ID);
`endif
        rst = 1'b1;
        #1;
        chk("err_cleared", E_ID);
        cyc();
        rst = 1'b0;

        // completion coincident with expiry
        set(1, 0, 0, 0);
        cyc();
        chk("co_grant", E_GI);
        set(0, 0, 0, 0);
        for (int k = 1; k < 20; k++) cyc();
        chk("co_hold", E_GI);
        set(0, 0, 1, 0);
        cyc();
        chk("co_done", E_CL);
        set(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc();
        chk("co_clear", E_CL);
        cyc();
        chk("co_idle", E_ID);

        // wrong pulse in GRANT_OUT, then reset mid inbound grant
        set(0, 1, 0, 0);
        cyc();
        chk("wp_grant", E_GO);
        set(0, 0, 1, 0);
        cyc();
        chk("wp_ignored", E_GO);
        set(0, 0, 0, 1);
        cyc();
        chk("wp_done", E_CL);
        set(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc();
        chk("wp_idle", E_ID);
        set(1, 0, 0, 0);
        cyc();
        chk("mr_grant", E_GI);
        set(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async", E_ID);
        cyc();
        chk("mr_held", E_ID);
        rst = 1'b0;
        set(1, 1, 0, 0);
        cyc();
        chk("mr_first_in", E_GI);
        set(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
